// File: rtl/state_machine.sv
// rtl/state_machine.sv - timed three-phase greenhouse sequencer (irrigate, soak, ventilate)
// Each phase lasts its programmed cycle count; dropping enable aborts to IDLE.
module state_machine #(
   parameter int DUR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DUR_W-1:0] state1_duration,
   input  logic [DUR_W-1:0] state2_duration,
   input  logic [DUR_W-1:0] state3_duration,
   output logic             done,
   output logic             irrigation_active,
   output logic             ventilation_active
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_S1   = 3'd1,
      ST_S2   = 3'd2,
      ST_S3   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [DUR_W-1:0] CNT_ONE = {{(DUR_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [DUR_W-1:0] cnt_q, cnt_d;
   logic [DUR_W-1:0] dur_sel;
   logic [DUR_W-1:0] last_cnt;
   logic             expired;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A zero duration behaves as one cycle so the sequence can never stall.
   always_comb begin
      dur_sel = '0;
      case (state_q)
         ST_S1:   dur_sel = state1_duration;
         ST_S2:   dur_sel = state2_duration;
         ST_S3:   dur_sel = state3_duration;
         default: dur_sel = '0;
      endcase
      last_cnt = (dur_sel == '0) ? '0 : (dur_sel - CNT_ONE);
      expired  = (cnt_q == last_cnt);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable) state_d = ST_S1;
         end
         ST_S1, ST_S2, ST_S3: begin
            // Abort outranks phase expiry.
            if (!enable) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (expired) begin
               cnt_d = '0;
               case (state_q)
                  ST_S1:   state_d = ST_S2;
                  ST_S2:   state_d = ST_S3;
                  default: state_d = ST_DONE;
               endcase
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: begin
            cnt_d = '0;
            if (!enable) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      done               = (state_q == ST_DONE);
      irrigation_active  = (state_q == ST_S1);
      ventilation_active = (state_q == ST_S3);
   end

endmodule

// File: tb/tb_state_machine.sv
// tb/tb_state_machine.sv - table-driven scoreboard bench for state_machine
module tb_state_machine;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] state1_duration;
   logic [7:0] state2_duration;
   logic [7:0] state3_duration;
   logic       done;
   logic       irrigation_active;
   logic       ventilation_active;

   int checks;
   int errors;

   typedef struct {
      logic [7:0] d1;
      logic [7:0] d2;
      logic [7:0] d3;
      int         e1;
      int         e2;
      int         e3;
      int         elat;
   } vec_t;

   vec_t vecs[6];
   vec_t exp_q[$];

   state_machine #(.DUR_W(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .state1_duration    (state1_duration),
      .state2_duration    (state2_duration),
      .state3_duration    (state3_duration),
      .done               (done),
      .irrigation_active  (irrigation_active),
      .ventilation_active (ventilation_active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Every sampled cycle also checks the output exclusivity invariants.
   task automatic tick();
      @(negedge clk);
      chk("inv_irr_and_vent", int'(irrigation_active && ventilation_active), 0);
      chk("inv_done_with_actuator",
          int'(done && (irrigation_active || ventilation_active)), 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  c1, c2, c3, lat;
      bit  seen;
      vec_t e;
      state1_duration = v.d1;
      state2_duration = v.d2;
      state3_duration = v.d3;
      exp_q.push_back(v);
      enable = 1'b1;
      c1 = 0; c2 = 0; c3 = 0; lat = 0; seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
         tick();
         lat++;
         if (done) seen = 1'b1;
         else begin
            if (irrigation_active)  c1++;
            if (!irrigation_active && !ventilation_active) c2++;
            if (ventilation_active) c3++;
         end
      end
      chk($sformatf("v%0d_done_seen", idx), int'(seen), 1);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_irr_cycles", idx), c1, e.e1);
      chk($sformatf("v%0d_soak_cycles", idx), c2, e.e2);
      chk($sformatf("v%0d_vent_cycles", idx), c3, e.e3);
      chk($sformatf("v%0d_latency", idx), lat, e.elat);
      repeat (3) tick();
      chk($sformatf("v%0d_done_held", idx), int'(done), 1);
      enable = 1'b0;
      tick();
      chk($sformatf("v%0d_done_fall", idx), int'(done), 0);
      tick();
   endtask

   initial begin
      bit found;
      checks = 0;
      errors = 0;
      vecs[0] = '{8'd5,   8'd3,  8'd4,  5,   3,  4,  13};
      vecs[1] = '{8'd10,  8'd8,  8'd6,  10,  8,  6,  25};
      vecs[2] = '{8'd15,  8'd12, 8'd10, 15,  12, 10, 38};
      vecs[3] = '{8'd0,   8'd0,  8'd0,  1,   1,  1,  4};
      vecs[4] = '{8'd1,   8'd2,  8'd1,  1,   2,  1,  5};
      vecs[5] = '{8'd255, 8'd1,  8'd0,  255, 1,  1,  258};

      reset = 1'b1;
      enable = 1'b0;
      state1_duration = 8'd0;
      state2_duration = 8'd0;
      state3_duration = 8'd0;
      #15;
      chk("reset_done", int'(done), 0);
      chk("reset_irr", int'(irrigation_active), 0);
      chk("reset_vent", int'(ventilation_active), 0);
      @(negedge clk);
      reset = 1'b0;
      tick();
      chk("idle_no_enable", int'({done, irrigation_active, ventilation_active}), 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Abort right after irrigation starts.
      state1_duration = 8'd15;
      state2_duration = 8'd12;
      state3_duration = 8'd10;
      enable = 1'b1;
      tick();
      chk("abort_irr_rise", int'(irrigation_active), 1);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("abort_idle", int'({done, irrigation_active, ventilation_active}), 0);
      end

      // Asynchronous reset while ventilating.
      state1_duration = 8'd5;
      state2_duration = 8'd3;
      state3_duration = 8'd4;
      enable = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick();
         if (ventilation_active) found = 1'b1;
      end
      chk("reach_state3", int'(found), 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      enable = 1'b0;
      #1;
      chk("async_reset_outputs", int'({done, irrigation_active, ventilation_active}), 0);
      tick();
      reset = 1'b0;
      tick();
      chk("post_reset_idle", int'({done, irrigation_active, ventilation_active}), 0);

      run_vec(vecs[0], 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
